// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: shares the character ROM read port between the fixed-latency display
// pipeline (always wins) and a best-effort CPU glyph readback with starvation detection.
module glyph_rom_arbiter #(
    parameter int CHARACTER_SET_COUNT = 27,
    parameter int MAX_WAIT = 64,
    localparam int IW = $clog2(CHARACTER_SET_COUNT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          disp_req,
    input  logic [IW-1:0] disp_idx,
    input  logic [3:0]    disp_row,
    output logic          disp_valid,
    output logic [7:0]    disp_bits,
    input  logic          cpu_req,
    input  logic [IW-1:0] cpu_idx,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [127:0]  cpu_rdata,
    output logic          starve_err,
    output logic          rom_en,
    output logic [IW-1:0] rom_idx,
    input  logic [127:0]  rom_data
);
    localparam logic [7:0] MW = 8'(MAX_WAIT);
    typedef enum logic [1:0] {IDLE, ISSUED, RSP} cpu_state_t;
    cpu_state_t state;
    logic       disp_tag;
    logic [3:0] row_q;
    logic [7:0] wait_cnt;
    always_comb begin
        cpu_gnt = rstn && !disp_req && cpu_req && state == IDLE;
        rom_en  = (rstn && disp_req) || cpu_gnt;
        rom_idx = !rom_en ? '0 : disp_req ? disp_idx : cpu_idx;
    end
    assign disp_valid = disp_tag;
    // Row 0 lives in the top byte, so the byte offset is (15 - row) * 8.
    assign disp_bits  = rom_data[{~row_q, 3'b000} +: 8];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            disp_tag   <= 1'b0;
            row_q      <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            wait_cnt   <= '0;
            starve_err <= 1'b0;
        end else begin
            disp_tag   <= disp_req;
            row_q      <= disp_row;
            cpu_rvalid <= state == ISSUED;
            if (state == ISSUED) cpu_rdata <= rom_data;
            state      <= state == IDLE ? (cpu_gnt ? ISSUED : IDLE) : state == ISSUED ? RSP : IDLE;
            wait_cnt   <= (cpu_req && !cpu_gnt) ? wait_cnt + {7'd0, wait_cnt != 8'hff} : '0;
            if (wait_cnt > MW) starve_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb_glyph_rom_arbiter: directed plus randomized checks of glyph_rom_arbiter against a
// cycle-count based behavioural model of arbitration, latency and starvation.
module tb_glyph_rom_arbiter;
    localparam int MW = 4;
    localparam logic [127:0] R3 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] R5 = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    logic clk = 1'b0;
    logic rstn, disp_req, cpu_req;
    logic [4:0] disp_idx, cpu_idx, rom_idx;
    logic [3:0] disp_row;
    logic disp_valid, cpu_gnt, cpu_rvalid, starve_err, rom_en;
    logic [7:0] disp_bits;
    logic [127:0] cpu_rdata;
    logic [127:0] rom_data = '0;
    logic [127:0] rom [32];
    int checks = 0, failures = 0;
    int c = 0, last_gnt = -100;
    logic [4:0] g_idx = '0;
    logic m_dv = 1'b0, m_err = 1'b0, e_gnt;
    logic [7:0] m_db = '0;
    logic [127:0] m_rdata = '0;
    int m_wait = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_idx];

    glyph_rom_arbiter #(.CHARACTER_SET_COUNT(27), .MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn), .disp_req(disp_req), .disp_idx(disp_idx), .disp_row(disp_row),
        .disp_valid(disp_valid), .disp_bits(disp_bits), .cpu_req(cpu_req), .cpu_idx(cpu_idx),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .starve_err(starve_err),
        .rom_en(rom_en), .rom_idx(rom_idx), .rom_data(rom_data)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic dq, input int di, input int dr,
                          input logic cq, input int ci);
        rstn = r; disp_req = dq; disp_idx = 5'(di); disp_row = 4'(dr);
        cpu_req = cq; cpu_idx = 5'(ci);
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic check_cycle();
        logic busy, e_en;
        logic [4:0] e_idx;
        busy  = (c == last_gnt + 1) || (c == last_gnt + 2);
        e_gnt = rstn && !disp_req && cpu_req && !busy;
        e_en  = (rstn && disp_req) || e_gnt;
        e_idx = !e_en ? 5'd0 : disp_req ? disp_idx : cpu_idx;
        chk("rom_en", 128'(rom_en), 128'(e_en));
        chk("rom_idx", 128'(rom_idx), 128'(e_idx));
        chk("cpu_gnt", 128'(cpu_gnt), 128'(e_gnt));
        chk("disp_valid", 128'(disp_valid), 128'(m_dv));
        if (m_dv) chk("disp_bits", 128'(disp_bits), 128'(m_db));
        chk("cpu_rvalid", 128'(cpu_rvalid), 128'(c == last_gnt + 2));
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("starve_err", 128'(starve_err), 128'(m_err));
    endtask

    task automatic model_update();
        logic [127:0] sh;
        if (!rstn) begin
            m_dv = 1'b0; m_rdata = '0; last_gnt = -100; m_wait = 0; m_err = 1'b0;
        end else begin
            m_dv = disp_req;
            sh = rom[disp_idx] >> (8 * (15 - int'(disp_row)));
            if (disp_req) m_db = sh[7:0];
            if (c == last_gnt + 1) m_rdata = rom[g_idx];
            if (e_gnt) begin last_gnt = c; g_idx = cpu_idx; end
            if (m_wait > MW) m_err = 1'b1;
            m_wait = (cpu_req && !e_gnt) ? (m_wait < 255 ? m_wait + 1 : 255) : 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        model_update();
        @(posedge clk);
        #1;
        c++;
    endtask

    initial begin
        logic creq;
        int cidx;
        for (int i = 0; i < 32; i++) rom[i] = {$urandom, $urandom, $urandom, $urandom};
        rom[3] = R3;
        rom[5] = R5;
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        repeat (3) tick();
        set_in(1, 0, 0, 0, 0, 0);
        repeat (5) tick();
        chk("idle_rom_en", 128'(rom_en), 128'(0));
        chk("idle_starve", 128'(starve_err), 128'(0));
        chk("idle_rdata", cpu_rdata, 128'(0));
        set_in(1, 1, 3, 2, 0, 0);
        #2;
        chk("disp_rom_en", 128'(rom_en), 128'(1));
        chk("disp_rom_idx", 128'(rom_idx), 128'(3));
        tick();
        chk("disp_valid_lit", 128'(disp_valid), 128'(1));
        chk("disp_bits_lit", 128'(disp_bits), 128'(8'h22));
        set_in(1, 0, 0, 0, 1, 5);
        #2;
        chk("cpu_gnt_lit", 128'(cpu_gnt), 128'(1));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        chk("cpu_rvalid_lit", 128'(cpu_rvalid), 128'(1));
        chk("cpu_rdata_lit", cpu_rdata, R5);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, i + 1, i, 0, 0);
            tick();
        end
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        chk("cpu_rdata_hold", cpu_rdata, R5);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, i + 7, i + 4, 1, 9);
            #2;
            chk("collide_no_gnt", 128'(cpu_gnt), 128'(0));
            tick();
        end
        set_in(1, 0, 0, 0, 1, 9);
        #2;
        chk("collide_gnt", 128'(cpu_gnt), 128'(1));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        chk("collide_rdata", cpu_rdata, rom[9]);
        repeat (2) tick();
        for (int k = 1; k <= 6; k++) begin
            set_in(1, 1, k, k, 1, 11);
            tick();
            if (k == 5) chk("starve_not_yet", 128'(starve_err), 128'(0));
        end
        chk("starve_set", 128'(starve_err), 128'(1));
        set_in(1, 0, 0, 0, 1, 11);
        #2;
        chk("starve_gnt", 128'(cpu_gnt), 128'(1));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        repeat (8) tick();
        chk("starve_sticky", 128'(starve_err), 128'(1));
        set_in(1, 0, 0, 0, 1, 13);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_no_rvalid", 128'(cpu_rvalid), 128'(0));
        chk("rst_rdata", cpu_rdata, 128'(0));
        chk("rst_starve", 128'(starve_err), 128'(0));
        set_in(1, 0, 0, 0, 1, 14);
        #2;
        chk("rst_regnt", 128'(cpu_gnt), 128'(1));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        chk("rst_rvalid", 128'(cpu_rvalid), 128'(1));
        chk("rst_rdata_new", cpu_rdata, rom[14]);
        creq = 1'b0;
        cidx = 0;
        for (int n = 0; n < 2000; n++) begin
            if (creq && last_gnt == c - 1) creq = 1'b0;
            else if (creq && $urandom_range(0, 49) == 0) creq = 1'b0;
            else if (!creq && $urandom_range(0, 2) == 0) begin
                creq = 1'b1;
                cidx = $urandom_range(0, 26);
            end
            if ($urandom_range(0, 299) == 0) begin
                creq = 1'b0;
                set_in(0, 0, 0, 0, 0, 0);
            end else begin
                set_in(1, $urandom_range(0, 1) == 1, $urandom_range(0, 26), $urandom_range(0, 15), creq, cidx);
            end
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glyph_rom_arbiter.md
Name: glyph_rom_arbiter

Overview:
- Sole owner of the character ROM's single read port (enable, index, 128-bit glyph data, 1-cycle registered read).
- Shares that port between two requesters:
  - the display pixel pipeline, which has hard real-time priority and fixed latency;
  - the APB-side glyph readback path, which uses a req/gnt/rvalid handshake and is best-effort.
- For the display, extracts the addressed 8-pixel row from the 16x8 glyph. For the CPU, returns the full 128-bit glyph in a holding register.

Parameters:
- CHARACTER_SET_COUNT, 27, number of glyphs in the ROM; index width IW = $clog2(CHARACTER_SET_COUNT).
- MAX_WAIT, 64, CPU wait cycles tolerated before the starvation flag sets (range 1..255).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- disp_req  in  1  display fetch request, single-cycle, no back-pressure.
- disp_idx  in  IW  glyph index for the display fetch.
- disp_row  in  4  glyph row (0 = top) for the display fetch.
- disp_valid  out  1  display row data valid.
- disp_bits  out  8  row pixels; bit 7 = leftmost pixel.
- cpu_req  in  1  CPU read request; held high until cpu_gnt.
- cpu_idx  in  IW  glyph index for CPU read; stable while cpu_req is high.
- cpu_gnt  out  1  one-cycle pulse: CPU read issued to ROM this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated.
- cpu_rdata  out  128  captured glyph; held until the next cpu_rvalid.
- starve_err  out  1  sticky: a CPU request waited more than MAX_WAIT cycles.
- rom_en  out  1  ROM enable (combinational).
- rom_idx  out  IW  ROM address (combinational).
- rom_data  in  128  ROM output, valid the cycle after rom_en.

Behaviour:
- Reset (rstn=0 at posedge):
  - disp_valid, cpu_gnt, cpu_rvalid, starve_err and the wait counter clear to 0.
  - cpu_rdata clears to 0.
  - All pipeline tags clear. The tag for any in-flight read is dropped, so no valid/rvalid fires after reset.
- Arbitration is combinational in cycle t:
  - disp_req=1: rom_en=1, rom_idx=disp_idx, cpu_gnt=0. Display always wins.
  - else if cpu_req=1 and cpu_busy=0: rom_en=1, rom_idx=cpu_idx, cpu_gnt=1.
  - else: rom_en=0, rom_idx=0.
- Per-cycle tags (registered at t):
  - disp_tag <= disp_req.
  - row_q <= disp_row.
  - cpu_tag <= cpu_gnt.
- Display path (latency exactly 1 cycle):
  - disp_valid = disp_tag.
  - disp_bits = rom_data[127-8*row_q -: 8], i.e. row 0 = bits 127:120. Combinational from rom_data.
  - When disp_valid=0, disp_bits is don't-care.
- CPU path states:
  - IDLE: on cpu_gnt go to ISSUED (cpu_busy=1).
  - ISSUED: cpu_rdata <= rom_data, cpu_rvalid=1 next cycle; go to RSP.
  - RSP: cpu_rvalid pulses; cpu_busy drops; return to IDLE.
  - CPU latency: gnt at t, rvalid and new rdata at t+2.
  - cpu_gnt is never asserted during ISSUED or RSP. A new request is granted at the earliest in the cycle after rvalid.
- Back-to-back display:
  - disp_req may be high on consecutive cycles; each yields disp_valid one cycle later.
  - The ROM is pipelined, so a display read at t+1 does not corrupt the CPU capture taken from the t+1 rom_data.
- Starvation counter (8-bit):
  - Increments each cycle cpu_req=1 && cpu_gnt=0, saturating at 255.
  - Clears on cpu_gnt or when cpu_req=0.
  - When the count exceeds MAX_WAIT, starve_err <= 1; it stays set until reset.
- cpu_req dropped before grant: the request is abandoned silently; no gnt and no rvalid.
- Index >= CHARACTER_SET_COUNT is passed through unchecked; the returned data is undefined.

Test Plan:
- Reset then idle: 5 cycles with no requests -> rom_en=0, all outputs 0, starve_err=0.
- Display read: disp_req=1, disp_idx=3, disp_row=2 at t -> rom_en=1, rom_idx=3 at t; at t+1 disp_valid=1 and disp_bits = ROM[3][111:104].
- CPU read, no contention: cpu_req=1, cpu_idx=5 -> cpu_gnt same cycle; cpu_rvalid at t+2 with cpu_rdata=ROM[5]; cpu_rdata still ROM[5] after 3 later display reads.
- Collision: disp_req and cpu_req both high for 3 cycles, then disp_req low -> cpu_gnt=0 for 3 cycles, then gnt; all 3 display rows correct at t+1 each; one cpu_rvalid.
- Starvation: MAX_WAIT=4, disp_req high 6 cycles with cpu_req high -> starve_err sets on the 6th wait cycle (count 5 > 4), grant on cycle 7, starve_err stays 1 until reset.
- Reset mid-op: rstn=0 in the cycle after cpu_gnt -> no cpu_rvalid, cpu_rdata=0, cpu_busy cleared; a new cpu_req is granted on the first cycle after reset release.
